// File: rtl/seq_cla_subtractor_pkg.sv
// Shared definitions for the sequential borrow-lookahead subtractor:
// FSM state encoding and the slice width processed per clock.
package seq_cla_subtractor_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_cla_subtractor_if.sv
// Operand/result handshake bundle for seq_cla_subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface seq_cla_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/seq_cla_subtractor_slice.sv
// 4-bit borrow-lookahead slice: d = a + ~b + cin, all carries from flat lookahead terms.
// cout is the carry; the corresponding borrow is ~cout.
module cla_sub_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ ~b;
    assign g = a & ~b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign d    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit lookahead slice per clock,
// valid/ready on both sides with a single operation in flight.
module seq_cla_subtractor
    import seq_cla_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_cla_subtractor_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("seq_cla_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic [SLICE_W-1:0] s_d;
    logic               s_cout;

    assign s_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign s_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    cla_sub_slice4 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (c_q),
        .d    (s_d),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        idx_d         = idx_q;
        diff_d        = diff_q;
        bout_d        = bout_q;
        ovf_d         = ovf_q;
        zero_d        = zero_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = ~bus.bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[int'(idx_q)*SLICE_W +: SLICE_W] = s_d;
                c_d   = s_cout;
                idx_d = idx_q + IDX_W'(1);
                // Flags are derived from diff_d so the final nibble is included.
                if (idx_q == LAST_IDX) begin
                    bout_d  = ~s_cout;
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
                    zero_d  = ~|diff_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Directed bench for seq_cla_subtractor (WIDTH=16) with hand-computed expected results.
module tb_seq_cla_subtractor;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    seq_cla_subtractor_if #(.WIDTH(WIDTH)) bus ();

    seq_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs [8] = '{
        '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
        '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0},
        '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
        '{16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
        '{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0},
        '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
        '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        check_eq({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.bin      = 1'($urandom);
    endtask

    // Called right after the accepting edge; result must appear exactly NSLICE edges later.
    task automatic await_result(input string tag);
        logic early = 1'b0;
        for (int k = 0; k < NSLICE; k++) begin
            @(negedge clk);
            if (bus.out_valid) early = 1'b1;
        end
        check_eq({tag, "/early_valid"}, 32'(early), 32'd0);
        @(negedge clk);
        check_eq({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check_eq({tag, "/diff"}, 32'(bus.diff), 32'(v.d));
        check_eq({tag, "/bout"}, 32'(bus.bout), 32'(v.bo));
        check_eq({tag, "/ovf"},  32'(bus.ovf),  32'(v.ov));
        check_eq({tag, "/zero"}, 32'(bus.zero), 32'(v.z));
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "/retire_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "/retire_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t hv;
        logic busy_ok;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("rst/in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst/diff",      32'(bus.diff),      32'd0);
        check_eq("rst/flags",     {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            launch(tag, vecs[i].a, vecs[i].b, vecs[i].bin);
            await_result(tag);
            check_result(tag, vecs[i]);
            retire(tag);
        end

        // Backpressure: result held while out_ready stays low
        launch("bp", vecs[0].a, vecs[0].b, vecs[0].bin);
        await_result("bp");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp%0d/out_valid", k), 32'(bus.out_valid), 32'd1);
            check_eq($sformatf("bp%0d/in_ready", k), 32'(bus.in_ready), 32'd0);
            check_result($sformatf("bp%0d", k), vecs[0]);
        end
        retire("bp");

        // in_valid held high throughout: second op accepted only after retire
        hv = '{16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = hv.a;
        bus.b        = hv.b;
        bus.bin      = hv.bin;
        check_eq("hs/in_ready0", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.a   = 16'h0010;
        bus.b   = 16'h0020;
        bus.bin = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < NSLICE; k++) begin
            @(negedge clk);
            if (bus.in_ready) busy_ok = 1'b0;
        end
        check_eq("hs/busy_in_ready", 32'(busy_ok), 32'd1);
        @(negedge clk);
        check_eq("hs/out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hs/done_in_ready", 32'(bus.in_ready), 32'd0);
        check_result("hs_a", hv);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq("hs/idle_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("hs/idle_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        await_result("hs_b");
        hv = '{16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, 1'b0, 1'b0};
        check_result("hs_b", hv);
        retire("hs_b");

        // Reset in the middle of RUN aborts the operation
        launch("rst_mid", 16'hABCD, 16'h1234, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_mid/in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_mid/diff",      32'(bus.diff),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hv = '{16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0};
        launch("post_rst", hv.a, hv.b, hv.bin);
        await_result("post_rst");
        check_result("post_rst", hv);
        retire("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
